// File: rtl/keypad_encoder_if.sv
// Keypad encoder bus: raw key lines and entry enable in, digit events and entry register out.
interface keypad_encoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enablen;
  logic [9:0]              keypad;
  logic [3:0]              bcd;
  logic                    valid;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    pressed;

  // Keypad / control side
  modport master (
    output enablen,
    output keypad,
    input  bcd,
    input  valid,
    input  digits,
    input  pressed
  );

  // Encoder side
  modport slave (
    input  enablen,
    input  keypad,
    output bcd,
    output valid,
    output digits,
    output pressed
  );
endinterface

// File: rtl/keypad_encoder.sv
// Microwave keypad encoder: qualifies a stable one-hot key press, emits a one-cycle
// BCD strobe per press and shifts accepted digits into the MM:SS entry register.
module keypad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS      = 4
) (
  input  logic             clk,
  input  logic             clear,
  keypad_encoder_if.slave  kif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DW     = 4 * NUM_DIGITS;
  localparam int unsigned KEYS   = 10;
  localparam logic [CNT_W-1:0] DC_CNT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_EMIT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t            state;
  logic [KEYS-1:0]   key_q;
  logic [KEYS-1:0]   latched_key;
  logic [3:0]        latched_code;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              key_onehot;
  logic              key_none;
  logic [3:0]        key_code;

  logic [3:0]        bcd_r;
  logic              valid_r;
  logic [DW-1:0]     digits_r;
  logic              pressed_r;

  // Register the raw key lines once so nothing downstream sees them combinationally
  always_ff @(posedge clk) begin
    if (clear) begin
      key_q <= '0;
    end else begin
      key_q <= kif.keypad;
    end
  end

  // Classify the sampled keys; direct bit-to-code mapping, only meaningful when one-hot
  always_comb begin
    key_onehot = $onehot(key_q);
    key_none   = (key_q == '0);
    count_inc  = count + CNT_W'(1);
    key_code   = '0;
    for (int k = 0; k < int'(KEYS); k++) begin
      if (key_q[k]) begin
        key_code = key_code | 4'(k);
      end
    end
  end

  // Press qualification FSM with registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= S_IDLE;
      count        <= '0;
      latched_key  <= '0;
      latched_code <= '0;
      bcd_r        <= '0;
      valid_r      <= 1'b0;
      digits_r     <= '0;
      pressed_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!kif.enablen && key_onehot) begin
            latched_key  <= key_q;
            latched_code <= key_code;
            count        <= CNT_W'(1);
            state        <= S_DEBOUNCE;
          end
        end

        S_DEBOUNCE: begin
          // Any change of the sampled keys or a lock aborts the press silently
          if (kif.enablen || (key_q != latched_key)) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            count <= count_inc;
            if (count_inc == DC_CNT) begin
              state <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          valid_r   <= 1'b1;
          bcd_r     <= latched_code;
          pressed_r <= 1'b1;
          digits_r  <= DW'({digits_r, latched_code});
          count     <= '0;
          state     <= S_HOLD;
        end

        S_HOLD: begin
          // Other keys while held are ignored; only a full release moves on
          if (key_none) begin
            count <= CNT_W'(1);
            state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (key_none) begin
            count <= count_inc;
            if (count_inc == DC_CNT) begin
              pressed_r <= 1'b0;
              count     <= '0;
              state     <= S_IDLE;
            end
          end else begin
            // Release bounce: back to waiting, never a new press
            count <= '0;
            state <= S_HOLD;
          end
        end

        default: begin
          count <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign kif.bcd     = bcd_r;
  assign kif.valid   = valid_r;
  assign kif.digits  = digits_r;
  assign kif.pressed = pressed_r;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: scoreboard of expected digit events plus
// directed timing checks on valid/pressed.
module tb_keypad_encoder;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  typedef struct {
    logic [3:0]    bcd;
    logic [DW-1:0] digits;
  } sb_item_t;

  logic clk;
  logic clear;

  keypad_encoder_if #(.NUM_DIGITS(NUM_DIGITS)) kif ();

  keypad_encoder #(
    .DEBOUNCE_CYCLES(4),
    .NUM_DIGITS     (NUM_DIGITS)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .kif  (kif)
  );

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n_valid;
  int unsigned n_pushed;
  sb_item_t    sb[$];
  sb_item_t    got_item;
  logic [DW-1:0] exp_digits;
  logic        prev_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the event a press is expected to produce and advance the digit model
  task automatic expect_press(input int k);
    sb_item_t it;
    exp_digits = {exp_digits[DW-5:0], 4'(k)};
    it.bcd     = 4'(k);
    it.digits  = exp_digits;
    sb.push_back(it);
    n_pushed++;
  endtask

  // Hold one key stable, then release it fully
  task automatic press(input int k, input int hold, input bit accepted);
    if (accepted) expect_press(k);
    kif.keypad = 10'(1 << k);
    repeat (hold) tick();
    kif.keypad = '0;
    repeat (8) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    repeat (2) tick();
    clear = 1'b0;
    exp_digits = '0;
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (kif.valid) begin
      n_valid++;
      check("valid_not_consecutive", 32'(prev_valid), 32'd0);
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got_item = sb.pop_front();
        check("sb_bcd", 32'(kif.bcd), 32'(got_item.bcd));
        check("sb_digits", 32'(kif.digits), 32'(got_item.digits));
      end
    end
    prev_valid = kif.valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] seq_exp [5];
    int            seq_key [5];
    seq_exp = '{16'h0001, 16'h0012, 16'h0123, 16'h1230, 16'h2304};
    seq_key = '{1, 2, 3, 0, 4};
    n_cmp = 0; n_err = 0; n_valid = 0; n_pushed = 0;
    prev_valid = 1'b0;
    exp_digits = '0;
    kif.keypad  = '0;
    kif.enablen = 1'b0;
    clear = 1'b1;
    repeat (3) tick();
    check("rst_bcd", 32'(kif.bcd), 32'd0);
    check("rst_valid", 32'(kif.valid), 32'd0);
    check("rst_digits", 32'(kif.digits), 32'd0);
    check("rst_pressed", 32'(kif.pressed), 32'd0);
    clear = 1'b0;

    // Key 5 stable: valid exactly after edge 5, pressed until release qualified
    expect_press(5);
    kif.keypad = 10'(1 << 5);
    tick();
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("k5_valid_e%0d", i), 32'(kif.valid), 32'(i == 5));
      check($sformatf("k5_pressed_e%0d", i), 32'(kif.pressed), 32'(i >= 5));
    end
    check("k5_bcd", 32'(kif.bcd), 32'd5);
    check("k5_digits", 32'(kif.digits), 32'h0005);
    kif.keypad = '0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("k5_rel_pressed_e%0d", i), 32'(kif.pressed), 32'(i < 4));
    end
    repeat (3) tick();

    // Key 3 bouncing with 2-cycle on/off, then stable
    for (int b = 0; b < 3; b++) begin
      kif.keypad = 10'(1 << 3);
      repeat (2) tick();
      kif.keypad = '0;
      repeat (2) tick();
    end
    check("bounce_no_valid", n_valid, 32'd1);
    press(3, 10, 1'b1);
    check("bounce_bcd", 32'(kif.bcd), 32'd3);

    // Digit sequence with full releases from a clean register
    do_clear();
    for (int i = 0; i < 5; i++) begin
      press(seq_key[i], 8, 1'b1);
      check($sformatf("seq_digits_%0d", i), 32'(kif.digits), 32'(seq_exp[i]));
    end

    // Keys 2+7 together, then 2 alone
    kif.keypad = 10'((1 << 2) | (1 << 7));
    repeat (8) tick();
    check("pair_no_valid", n_valid, 32'd7);
    press(2, 10, 1'b1);
    check("pair_bcd", 32'(kif.bcd), 32'd2);

    // Key 8 accepted, release glitches, then final release
    expect_press(8);
    kif.keypad = 10'(1 << 8);
    repeat (8) tick();
    for (int g = 0; g < 2; g++) begin
      kif.keypad = '0;
      repeat (2) begin tick(); check("glitch_pressed", 32'(kif.pressed), 32'd1); end
      kif.keypad = 10'(1 << 8);
      repeat (2) begin tick(); check("glitch_pressed", 32'(kif.pressed), 32'd1); end
    end
    kif.keypad = '0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("k8_rel_pressed_e%0d", i), 32'(kif.pressed), 32'(i < 4));
    end
    repeat (3) tick();
    check("k8_single_valid", n_valid, 32'd9);

    // Locked entry: key 9 ignored, digits retained
    kif.enablen = 1'b1;
    press(9, 10, 1'b0);
    kif.enablen = 1'b0;
    check("locked_digits", 32'(kif.digits), 32'(exp_digits));

    // Lock raised mid-debounce aborts the press
    kif.keypad = 10'(1 << 6);
    repeat (3) tick();
    kif.enablen = 1'b1;
    repeat (8) tick();
    kif.keypad = '0;
    repeat (8) tick();
    kif.enablen = 1'b0;
    check("abort_digits", 32'(kif.digits), 32'(exp_digits));
    check("abort_pressed", 32'(kif.pressed), 32'd0);

    // clear in HOLD, key still held afterwards counts as a fresh press
    expect_press(4);
    kif.keypad = 10'(1 << 4);
    repeat (8) tick();
    clear = 1'b1;
    tick();
    check("clr_bcd", 32'(kif.bcd), 32'd0);
    check("clr_valid", 32'(kif.valid), 32'd0);
    check("clr_digits", 32'(kif.digits), 32'd0);
    check("clr_pressed", 32'(kif.pressed), 32'd0);
    clear = 1'b0;
    exp_digits = '0;
    expect_press(4);
    repeat (10) tick();
    kif.keypad = '0;
    repeat (8) tick();
    check("fresh_digits", 32'(kif.digits), 32'h0004);

    check("valid_total", n_valid, n_pushed);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
